// File: rtl/dispatcher_pkg.sv
// Shared types for the voice allocator: the latched event record, the FSM
// state encoding and the action decided in SEARCH and applied in COMMIT.
package dispatcher_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  vel;
    } voice_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_GATHER,
        ST_COMMIT
    } alloc_state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ALLOC,
        ACT_RETRIG,
        ACT_STEAL,
        ACT_OFF
    } alloc_act_t;

endpackage

// File: rtl/voice_search.sv
// Combinational priority encoder over the voice pool: lowest active voice whose
// note matches the key, and lowest inactive voice.
module voice_search #(
    parameter int  VOICES = 8,
    parameter int  NOTE_W = 7,
    localparam int IDX_W  = $clog2(VOICES)
) (
    input  logic [VOICES-1:0]        active_i,
    input  logic [VOICES*NOTE_W-1:0] notes_i,
    input  logic [NOTE_W-1:0]        key_i,
    output logic                     hit_o,
    output logic [IDX_W-1:0]         hit_idx_o,
    output logic                     free_o,
    output logic [IDX_W-1:0]         free_idx_o
);

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_o     = 1'b0;
        free_idx_o = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (active_i[i] && (notes_i[i*NOTE_W +: NOTE_W] == key_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!active_i[i]) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-on/off to voice-pool allocator with one event in flight.
// Random voice stealing on a full pool is built only when VOICE_ALLOC_STEAL_EN is defined.
module voice_allocator #(
    parameter int VOICES = 8,
    parameter int NOTE_W = dispatcher_pkg::NOTE_W,
    parameter int VEL_W  = dispatcher_pkg::VEL_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rand_bit,
    output logic                     rand_en,
    input  logic                     evt_valid,
    output logic                     evt_ready,
    input  logic                     evt_on,
    input  logic [NOTE_W-1:0]        evt_note,
    input  logic [VEL_W-1:0]         evt_vel,
    output logic [VOICES-1:0]        voice_active,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [VOICES*VEL_W-1:0]  voice_vel,
    output logic [VOICES-1:0]        voice_start,
    output logic [VOICES-1:0]        voice_stop
);
    import dispatcher_pkg::*;

    localparam int IDX_W = $clog2(VOICES);

    alloc_state_t             state_q, state_d;
    voice_evt_t               evt_q, evt_d;
    alloc_act_t               act_q, act_d;
    logic [IDX_W-1:0]         tgt_q, tgt_d;
    logic [VOICES-1:0]        active_q, active_d;
    logic [VOICES*NOTE_W-1:0] note_q, note_d;
    logic [VOICES*VEL_W-1:0]  vel_q, vel_d;
    logic [VOICES-1:0]        start_q, start_d;
    logic [VOICES-1:0]        stop_q, stop_d;
    logic                     hit, free;
    logic [IDX_W-1:0]         hit_idx, free_idx;

`ifdef VOICE_ALLOC_STEAL_EN
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    assign rand_en = (state_q == ST_GATHER);
`else
    logic                     unused_rand;
    assign unused_rand = rand_bit;
    assign rand_en     = 1'b0;
`endif

    voice_search #(.VOICES(VOICES), .NOTE_W(NOTE_W)) u_search (
        .active_i  (active_q),
        .notes_i   (note_q),
        .key_i     (evt_q.note),
        .hit_o     (hit),
        .hit_idx_o (hit_idx),
        .free_o    (free),
        .free_idx_o(free_idx)
    );

    assign evt_ready    = (state_q == ST_IDLE) && !reset;
    assign voice_active = active_q;
    assign voice_note   = note_q;
    assign voice_vel    = vel_q;
    assign voice_start  = start_q;
    assign voice_stop   = stop_q;

    always_comb begin
        state_d  = state_q;
        evt_d    = evt_q;
        act_d    = act_q;
        tgt_d    = tgt_q;
        active_d = active_q;
        note_d   = note_q;
        vel_d    = vel_q;
        start_d  = '0;
        stop_d   = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (evt_valid) begin
                    evt_d   = '{on: evt_on, note: evt_note, vel: evt_vel};
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                state_d = ST_COMMIT;
                act_d   = ACT_NONE;
                tgt_d   = '0;
`ifdef VOICE_ALLOC_STEAL_EN
                cnt_d   = '0;
`endif
                if (evt_q.on) begin
                    if (hit) begin
                        act_d = ACT_RETRIG;
                        tgt_d = hit_idx;
                    end else if (free) begin
                        act_d = ACT_ALLOC;
                        tgt_d = free_idx;
                    end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                        act_d   = ACT_STEAL;
                        state_d = ST_GATHER;
`else
                        act_d   = ACT_NONE;
`endif
                    end
                end else if (hit) begin
                    act_d = ACT_OFF;
                    tgt_d = hit_idx;
                end
            end
`ifdef VOICE_ALLOC_STEAL_EN
            ST_GATHER: begin
                // Victim index is assembled MSB first from the serial LFSR bit.
                tgt_d = IDX_W'({tgt_q, rand_bit});
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(IDX_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_IDLE;
                case (act_q)
                    ACT_ALLOC, ACT_STEAL: begin
                        active_d[tgt_q]                 = 1'b1;
                        note_d[tgt_q*NOTE_W +: NOTE_W]  = evt_q.note;
                        vel_d[tgt_q*VEL_W +: VEL_W]     = evt_q.vel;
                        start_d[tgt_q]                  = 1'b1;
                        stop_d[tgt_q]                   = (act_q == ACT_STEAL);
                    end
                    ACT_RETRIG: begin
                        vel_d[tgt_q*VEL_W +: VEL_W]     = evt_q.vel;
                        start_d[tgt_q]                  = 1'b1;
                    end
                    ACT_OFF: begin
                        active_d[tgt_q]                 = 1'b0;
                        note_d[tgt_q*NOTE_W +: NOTE_W]  = '0;
                        vel_d[tgt_q*VEL_W +: VEL_W]     = '0;
                        stop_d[tgt_q]                   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            evt_q    <= '0;
            act_q    <= ACT_NONE;
            tgt_q    <= '0;
            active_q <= '0;
            note_q   <= '0;
            vel_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            evt_q    <= evt_d;
            act_q    <= act_d;
            tgt_q    <= tgt_d;
            active_q <= active_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
`ifdef VOICE_ALLOC_STEAL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized scoreboard bench for voice_allocator; expected completions come from
// an array-based model of the voice pool and are popped by an independent monitor.
module tb_voice_allocator;

    localparam int VOICES = 8;
    localparam int IDX_W  = $clog2(VOICES);
    localparam int NW     = 7;

    logic                 clock;
    logic                 reset;
    logic                 rand_bit;
    logic                 rand_en;
    logic                 evt_valid;
    logic                 evt_ready;
    logic                 evt_on;
    logic [NW-1:0]        evt_note;
    logic [NW-1:0]        evt_vel;
    logic [VOICES-1:0]    voice_active;
    logic [VOICES*NW-1:0] voice_note;
    logic [VOICES*NW-1:0] voice_vel;
    logic [VOICES-1:0]    voice_start;
    logic [VOICES-1:0]    voice_stop;

    voice_allocator #(.VOICES(VOICES)) dut (
        .clock       (clock),
        .reset       (reset),
        .rand_bit    (rand_bit),
        .rand_en     (rand_en),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_on      (evt_on),
        .evt_note    (evt_note),
        .evt_vel     (evt_vel),
        .voice_active(voice_active),
        .voice_note  (voice_note),
        .voice_vel   (voice_vel),
        .voice_start (voice_start),
        .voice_stop  (voice_stop)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [VOICES-1:0]    start;
        logic [VOICES-1:0]    stop;
        logic [VOICES-1:0]    active;
        logic [VOICES*NW-1:0] notes;
        logic [VOICES*NW-1:0] vels;
        logic [31:0]          lat;
        logic [31:0]          rcnt;
    } exp_t;

    exp_t exp_q[$];
    bit   rbits_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // pool model
    bit m_active[VOICES];
    int m_note[VOICES];
    int m_vel[VOICES];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // serial random source: shifts out the planned victim while rand_en is high
    initial begin
        rand_bit = 1'b0;
        forever begin
            @(negedge clock);
            if (rand_en && rbits_q.size() > 0) rand_bit = rbits_q.pop_front();
            else rand_bit = 1'($urandom_range(0, 1));
        end
    end

    // monitor: one completion per accepted event, pulses silent otherwise
    initial begin
        bit   in_flight = 0;
        int   acc_edge  = 0;
        int   rcnt      = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                in_flight = 0;
                rcnt      = 0;
                continue;
            end
            if (in_flight && evt_ready) begin
                in_flight = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("start", 64'(voice_start), 64'(e.start));
                    chk("stop", 64'(voice_stop), 64'(e.stop));
                    chk("active", 64'(voice_active), 64'(e.active));
                    chk("notes", 64'(voice_note), 64'(e.notes));
                    chk("vels", 64'(voice_vel), 64'(e.vels));
                    chk("latency", 64'(cyc - acc_edge), 64'(e.lat));
                    chk("rand_en_cycles", 64'(rcnt), 64'(e.rcnt));
                end
            end else begin
                chk("idle_pulses", {48'd0, voice_start, voice_stop}, 64'd0);
                if (in_flight && (cyc - acc_edge > 40)) begin
                    chk("completion_timeout", 64'd1, 64'd0);
                    in_flight = 0;
                end
            end
            if (rand_en) rcnt++;
            if (evt_valid && evt_ready) begin
                in_flight = 1;
                acc_edge  = cyc + 1;
                rcnt      = 0;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < VOICES; i++) begin
            m_active[i] = 0;
            m_note[i]   = 0;
            m_vel[i]    = 0;
        end
    endtask

    // called and returns at posedge+1
    task automatic do_reset();
        reset = 1'b1;
        rbits_q.delete();
        model_clear();
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 64'(evt_ready), 64'd0);
        chk("rst_active", 64'(voice_active), 64'd0);
        chk("rst_notes", 64'(voice_note), 64'd0);
        chk("rst_vels", 64'(voice_vel), 64'd0);
        chk("rst_pulses", {48'd0, voice_start, voice_stop}, 64'd0);
        chk("rst_rand_en", 64'(rand_en), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 64'(evt_ready), 64'd1);
        @(posedge clock);
        #1;
    endtask

    // driver: waits for ready, records the model's expected outcome, issues the event
    task automatic send(input bit on, input int note, input int vel, input int victim);
        exp_t e;
        int   hit  = -1;
        int   free = -1;
        int   v;
        int   n    = 0;
        while (!evt_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!evt_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            return;
        end
        e = '0;
        e.lat = 2;
        for (int i = 0; i < VOICES; i++)
            if (m_active[i] && m_note[i] == note && hit < 0) hit = i;
        for (int i = 0; i < VOICES; i++)
            if (!m_active[i] && free < 0) free = i;
        if (on) begin
            if (hit >= 0) begin
                m_vel[hit]   = vel;
                e.start[hit] = 1'b1;
            end else if (free >= 0) begin
                m_active[free] = 1;
                m_note[free]   = note;
                m_vel[free]    = vel;
                e.start[free]  = 1'b1;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                v = (victim < 0) ? int'($urandom_range(0, VOICES - 1)) : victim;
                for (int b = IDX_W - 1; b >= 0; b--) rbits_q.push_back(bit'((v >> b) & 1));
                m_note[v]  = note;
                m_vel[v]   = vel;
                e.start[v] = 1'b1;
                e.stop[v]  = 1'b1;
                e.lat      = 2 + IDX_W;
                e.rcnt     = IDX_W;
`else
                v = victim;
`endif
            end
        end else if (hit >= 0) begin
            m_active[hit] = 0;
            m_note[hit]   = 0;
            m_vel[hit]    = 0;
            e.stop[hit]   = 1'b1;
        end
        for (int i = 0; i < VOICES; i++) begin
            e.active[i]         = m_active[i];
            e.notes[i*NW +: NW] = NW'(m_note[i]);
            e.vels[i*NW +: NW]  = NW'(m_vel[i]);
        end
        exp_q.push_back(e);
        evt_valid = 1'b1;
        evt_on    = on;
        evt_note  = NW'(note);
        evt_vel   = NW'(vel);
        @(posedge clock);
        #1;
        // busy-cycle noise that must be ignored
        evt_valid = 1'($urandom_range(0, 1));
        evt_on    = 1'($urandom_range(0, 1));
        evt_note  = NW'($urandom_range(0, 127));
        evt_vel   = NW'($urandom_range(0, 127));
        @(posedge clock);
        #1;
        evt_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        evt_valid = 1'b0;
        evt_on    = 1'b0;
        evt_note  = '0;
        evt_vel   = '0;
        @(posedge clock);
        #1;
        do_reset();

        // first allocation, fill, release, reuse
        send(1, 60, 100, -1);
        for (int k = 61; k <= 67; k++) send(1, k, int'($urandom_range(1, 127)), -1);
        send(0, 63, 0, -1);
        send(1, 70, 55, -1);
        // full pool: steal victim 5 (bits 1,0,1) or drop
        send(1, 72, 90, 5);

        // retrigger and note-off miss
        do_reset();
        send(1, 60, 100, -1);
        send(1, 60, 40, -1);
        send(0, 99, 0, -1);

        // reset while the steal is gathering
        do_reset();
        for (int k = 0; k < VOICES; k++) send(1, 80 + k, 10 + k, -1);
        send(1, 100, 20, -1);
`ifdef VOICE_ALLOC_STEAL_EN
        n = 0;
        while (!rand_en && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("gather_seen", 64'(rand_en), 64'd1);
`endif
        do_reset();

        // randomized traffic
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            send(($urandom_range(0, 9) < 6), 60 + int'($urandom_range(0, 11)),
                 int'($urandom_range(0, 127)), -1);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
